// File: rtl/poli_horner_if.sv
// poli_horner_if: handshake and data bundle between a poli_horner evaluator and its requester
// Signals: inicio/pronto start and acknowledge requests, X evaluation point, COEF packed coefficients (COEF[k*WIDTH +: WIDTH] multiplies X^k),
//          Resultado result, LED result valid, ocupado busy, estouro sticky overflow
interface poli_horner_if #(
    parameter int WIDTH = 16,
    parameter int GRAU  = 2
);
    logic                      inicio;
    logic                      pronto;
    logic [WIDTH-1:0]          X;
    logic [(GRAU+1)*WIDTH-1:0] COEF;
    logic [WIDTH-1:0]          Resultado;
    logic                      LED;
    logic                      ocupado;
    logic                      estouro;
    modport master (output inicio, pronto, X, COEF, input Resultado, LED, ocupado, estouro);
    modport slave  (input inicio, pronto, X, COEF, output Resultado, LED, ocupado, estouro);
endinterface

// File: rtl/poli_horner.sv
// poli_horner: Horner-rule polynomial evaluator, one multiply-accumulate step per clock, inicio/pronto handshake
// Ports: ck rising-edge clock; rst asynchronous active-low reset;
//        bus (poli_horner_if.slave): inicio, pronto, X, COEF in; Resultado, LED, ocupado, estouro out (all registered)
// Option: define POLI_SAT_EN for saturating steps; otherwise steps wrap modulo 2^WIDTH
module poli_horner #(
    parameter int WIDTH = 16,
    parameter int GRAU  = 2
) (
    input  logic          ck,
    input  logic          rst,
    poli_horner_if.slave  bus
);
    localparam int IW = (GRAU < 2) ? 1 : $clog2(GRAU);
    typedef enum logic [1:0] {OCIOSO, CALC, FIM} state_t;
    state_t                  r_state, w_next;
    logic [WIDTH-1:0]        r_x, r_acc, r_res, w_coef, w_step;
    logic [GRAU*WIDTH-1:0]   r_c;
    logic [IW-1:0]           r_i;
    logic                    r_ovf, r_led, r_ocu, w_led, w_ocu, w_ov;
    logic [2*WIDTH-1:0]      w_prod;
    logic [WIDTH:0]          w_sum;
    assign w_prod = {{WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_x};
    assign w_coef = r_c[r_i*WIDTH +: WIDTH];
    assign w_sum  = {1'b0, w_prod[WIDTH-1:0]} + {1'b0, w_coef};
    assign w_ov   = (|w_prod[2*WIDTH-1:WIDTH]) | w_sum[WIDTH];
`ifdef POLI_SAT_EN
    assign w_step = w_ov ? '1 : w_sum[WIDTH-1:0];
`else
    assign w_step = w_sum[WIDTH-1:0];
`endif
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) r_state <= OCIOSO;
        else      r_state <= w_next;
    end
    // pronto is only looked at in FIM, so a simultaneous inicio there is dropped
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            OCIOSO:  w_next = bus.inicio ? CALC : OCIOSO;
            CALC:    w_next = (r_i == '0) ? FIM : CALC;
            FIM:     w_next = bus.pronto ? OCIOSO : FIM;
            default: w_next = OCIOSO;
        endcase
    end
    // decoded from the next state so the flags can be registered without a cycle of lag
    always_comb begin
        w_led = (w_next == FIM);
        w_ocu = (w_next == CALC);
    end
    // the top coefficient goes straight into acc, so only the lower GRAU words are kept
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_c   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
            r_led <= 1'b0;
            r_ocu <= 1'b0;
        end else begin
            r_led <= w_led;
            r_ocu <= w_ocu;
            if (r_state == OCIOSO && bus.inicio) begin
                r_x   <= bus.X;
                r_c   <= bus.COEF[GRAU*WIDTH-1:0];
                r_acc <= bus.COEF[GRAU*WIDTH +: WIDTH];
                r_i   <= IW'(GRAU-1);
                r_ovf <= 1'b0;
            end else if (r_state == CALC) begin
                r_acc <= w_step;
                r_i   <= r_i - 1'b1;
                r_ovf <= r_ovf | w_ov;
                if (r_i == '0) r_res <= w_step;
            end
        end
    end
    assign bus.Resultado = r_res;
    assign bus.LED       = r_led;
    assign bus.ocupado   = r_ocu;
    assign bus.estouro   = r_ovf;
endmodule

// File: tb/tb_poli_horner.sv
// tb_poli_horner: self-checking bench for poli_horner at GRAU=2 and GRAU=4, WIDTH=16
module tb_poli_horner;
    logic ck, rst;
    int   errs = 0;
    int   checks = 0;
    poli_horner_if #(.WIDTH(16), .GRAU(2)) b2();
    poli_horner_if #(.WIDTH(16), .GRAU(4)) b4();
    poli_horner #(.WIDTH(16), .GRAU(2)) d2 (.ck(ck), .rst(rst), .bus(b2));
    poli_horner #(.WIDTH(16), .GRAU(4)) d4 (.ck(ck), .rst(rst), .bus(b4));
    initial ck = 1'b0;
    always #5 ck = ~ck;
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    // reference: wrap result as the exact polynomial sum mod 2^16; overflow and saturation follow the Horner steps
    function automatic void model(input int g, input logic [15:0] x, input logic [15:0] c [8],
                                  output logic [15:0] r, output logic ov);
        longint unsigned a, p, s, tot, pw;
        bit o;
        a = c[g];
        ov = 1'b0;
        for (int k = g - 1; k >= 0; k--) begin
            p = a * x;
            s = (p % 65536) + c[k];
            o = (p >= 65536) || (s >= 65536);
            if (o) ov = 1'b1;
`ifdef POLI_SAT_EN
            a = o ? 65535 : s;
`else
            a = s % 65536;
`endif
        end
`ifdef POLI_SAT_EN
        r = a[15:0];
`else
        tot = 0;
        pw = 1;
        for (int k = 0; k <= g; k++) begin
            tot = (tot + c[k] * pw) % 65536;
            pw = (pw * x) % 65536;
        end
        r = tot[15:0];
`endif
    endfunction
    task automatic tick();
        @(posedge ck);
        #1;
    endtask
    task automatic go2(input logic [15:0] x, input logic [47:0] cf);
        @(negedge ck);
        b2.X = x;
        b2.COEF = cf;
        b2.inicio = 1'b1;
        tick();
        b2.inicio = 1'b0;
    endtask
    task automatic go4(input logic [15:0] x, input logic [79:0] cf);
        @(negedge ck);
        b4.X = x;
        b4.COEF = cf;
        b4.inicio = 1'b1;
        tick();
        b4.inicio = 1'b0;
    endtask
    task automatic ack2();
        @(negedge ck);
        b2.pronto = 1'b1;
        tick();
        b2.pronto = 1'b0;
    endtask
    task automatic ack4();
        @(negedge ck);
        b4.pronto = 1'b1;
        tick();
        b4.pronto = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b0;
        b2.inicio = 0; b2.pronto = 0; b2.X = 0; b2.COEF = 0;
        b4.inicio = 0; b4.pronto = 0; b4.X = 0; b4.COEF = 0;
        tick();
        tick();
        checks++;
        if ({b2.Resultado, b2.LED, b2.ocupado, b2.estouro} !== 19'd0) begin
            errs++;
            $display("FAIL reset_d2 got %h want 0", {b2.Resultado, b2.LED, b2.ocupado, b2.estouro});
        end
        checks++;
        if ({b4.Resultado, b4.LED, b4.ocupado, b4.estouro} !== 19'd0) begin
            errs++;
            $display("FAIL reset_d4 got %h want 0", {b4.Resultado, b4.LED, b4.ocupado, b4.estouro});
        end
        @(negedge ck);
        rst = 1'b1;
        tick();
    endtask
    task automatic test_basic();
        go2(16'd2, {16'd1, 16'd3, 16'd4});
        checks++;
        if ({b2.ocupado, b2.LED} !== 2'b10) begin
            errs++;
            $display("FAIL basic_e0 ocupado/LED got %b want 10", {b2.ocupado, b2.LED});
        end
        tick();
        checks++;
        if ({b2.ocupado, b2.LED} !== 2'b10) begin
            errs++;
            $display("FAIL basic_e1 ocupado/LED got %b want 10", {b2.ocupado, b2.LED});
        end
        tick();
        checks++;
        if ({b2.ocupado, b2.LED, b2.estouro} !== 3'b010 || b2.Resultado !== 16'd14) begin
            errs++;
            $display("FAIL basic_done got res=%0d flags=%b want res=14 flags=010",
                     b2.Resultado, {b2.ocupado, b2.LED, b2.estouro});
        end
        ack2();
        checks++;
        if (b2.LED !== 1'b0 || b2.Resultado !== 16'd14) begin
            errs++;
            $display("FAIL basic_ack got LED=%b res=%0d want LED=0 res=14", b2.LED, b2.Resultado);
        end
    endtask
    task automatic test_grau4();
        go4(16'd3, {5{16'd1}});
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                tick();
                checks++;
                if (b4.LED !== 1'b0 || b4.ocupado !== 1'b1) begin
                    errs++;
                    $display("FAIL grau4_busy step %0d got LED=%b ocupado=%b want 0 1", k, b4.LED, b4.ocupado);
                end
            end else begin
                tick();
                checks++;
                if (b4.LED !== 1'b1 || b4.Resultado !== 16'd121) begin
                    errs++;
                    $display("FAIL grau4_done got LED=%b res=%0d want LED=1 res=121", b4.LED, b4.Resultado);
                end
            end
        end
        ack4();
    endtask
    task automatic test_overflow();
        logic [15:0] want;
`ifdef POLI_SAT_EN
        want = 16'hFFFF;
`else
        want = 16'h0000;
`endif
        go2(16'h0100, {16'd1, 16'd0, 16'd0});
        tick();
        tick();
        checks++;
        if (b2.Resultado !== want || b2.estouro !== 1'b1 || b2.LED !== 1'b1) begin
            errs++;
            $display("FAIL ovf got res=%h estouro=%b LED=%b want res=%h estouro=1 LED=1",
                     b2.Resultado, b2.estouro, b2.LED, want);
        end
        ack2();
        go2(16'd2, {16'd1, 16'd3, 16'd4});
        checks++;
        if (b2.estouro !== 1'b0) begin
            errs++;
            $display("FAIL ovf_clear_on_start got estouro=%b want 0", b2.estouro);
        end
        tick();
        tick();
        checks++;
        if (b2.Resultado !== 16'd14 || b2.estouro !== 1'b0) begin
            errs++;
            $display("FAIL ovf_next got res=%0d estouro=%b want 14 0", b2.Resultado, b2.estouro);
        end
        ack2();
    endtask
    task automatic test_reset_mid();
        go4(16'd3, {5{16'd1}});
        tick();
        tick();
        checks++;
        if (b4.ocupado !== 1'b1 || b4.Resultado !== 16'd121) begin
            errs++;
            $display("FAIL rstmid_pre got ocupado=%b res=%0d want 1 121", b4.ocupado, b4.Resultado);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({b4.Resultado, b4.LED, b4.ocupado, b4.estouro} !== 19'd0) begin
            errs++;
            $display("FAIL rstmid_async got %h want 0", {b4.Resultado, b4.LED, b4.ocupado, b4.estouro});
        end
        @(negedge ck);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (b4.LED !== 1'b0 || b4.ocupado !== 1'b0) begin
                errs++;
                $display("FAIL rstmid_idle cycle %0d got LED=%b ocupado=%b want 0 0", k, b4.LED, b4.ocupado);
            end
        end
    endtask
    task automatic test_hold_inicio();
        @(negedge ck);
        b2.X = 16'd2;
        b2.COEF = {16'd1, 16'd3, 16'd4};
        b2.inicio = 1'b1;
        tick();
        @(negedge ck);
        b2.X = 16'd7;
        b2.COEF = {16'd9, 16'd9, 16'd9};
        tick();
        tick();
        checks++;
        if (b2.Resultado !== 16'd14 || b2.LED !== 1'b1) begin
            errs++;
            $display("FAIL hold_result got res=%0d LED=%b want 14 1", b2.Resultado, b2.LED);
        end
        tick();
        tick();
        checks++;
        if (b2.LED !== 1'b1 || b2.ocupado !== 1'b0 || b2.Resultado !== 16'd14) begin
            errs++;
            $display("FAIL hold_norestart got LED=%b ocupado=%b res=%0d want 1 0 14", b2.LED, b2.ocupado, b2.Resultado);
        end
        @(negedge ck);
        b2.pronto = 1'b1;
        tick();
        checks++;
        if (b2.LED !== 1'b0 || b2.ocupado !== 1'b0) begin
            errs++;
            $display("FAIL both_pronto_wins got LED=%b ocupado=%b want 0 0", b2.LED, b2.ocupado);
        end
        @(negedge ck);
        b2.pronto = 1'b0;
        b2.inicio = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (b2.ocupado !== 1'b0 || b2.LED !== 1'b0) begin
                errs++;
                $display("FAIL both_nostart cycle %0d got ocupado=%b LED=%b want 0 0", k, b2.ocupado, b2.LED);
            end
        end
    endtask
    task automatic test_random();
        logic [15:0] c [8];
        logic [15:0] x, er;
        logic eo;
        int g, cyc;
        for (int n = 0; n < 24; n++) begin
            g = (n % 2 == 0) ? 2 : 4;
            x = (n % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
            for (int k = 0; k < 8; k++) c[k] = (n % 4 == 1) ? 16'($urandom) : 16'($urandom_range(0, 50));
            model(g, x, c, er, eo);
            if (g == 2) go2(x, {c[2], c[1], c[0]});
            else        go4(x, {c[4], c[3], c[2], c[1], c[0]});
            cyc = 0;
            while (((g == 2) ? b2.LED : b4.LED) !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            checks++;
            if (cyc != g) begin
                errs++;
                $display("FAIL rand_latency n=%0d got %0d cycles want %0d", n, cyc, g);
            end
            checks++;
            if (((g == 2) ? b2.Resultado : b4.Resultado) !== er || ((g == 2) ? b2.estouro : b4.estouro) !== eo) begin
                errs++;
                $display("FAIL rand_result n=%0d g=%0d got res=%h ovf=%b want res=%h ovf=%b", n, g,
                         (g == 2) ? b2.Resultado : b4.Resultado, (g == 2) ? b2.estouro : b4.estouro, er, eo);
            end
            if (g == 2) ack2();
            else        ack4();
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_grau4();
        test_overflow();
        test_reset_mid();
        test_hold_inicio();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/poli_horner.md
# poli_horner

Parametrised polynomial evaluator: computes P(X) = Σ COEF[k]·X^k for a configurable degree and word width using Horner's rule, one multiply-accumulate step per clock. It is the next generation of the team's fixed second-degree evaluator and keeps its start/acknowledge handshake (inicio/pronto) and its done indicator (LED). It adds arbitrary degree, a busy flag, and overflow detection.

## Interface

Parameters:
- WIDTH, 16: word width of X, each coefficient, and Resultado (4..32).
- GRAU, 2: polynomial degree N (1..7); GRAU+1 coefficients.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inicio  in  1  start request, sampled on the rising edge of ck.
- pronto  in  1  result acknowledge, sampled on the rising edge of ck.
- X  in  WIDTH  unsigned evaluation point.
- COEF  in  (GRAU+1)*WIDTH  unsigned coefficients; COEF[k*WIDTH +: WIDTH] multiplies X^k.
- Resultado  out  WIDTH  registered result; holds until the next accepted start.
- LED  out  1  result valid (high in FIM).
- ocupado  out  1  high in CALC.
- estouro  out  1  sticky overflow flag for the current or last evaluation.

## Operation

- Reset (rst=0, asynchronous): state=OCIOSO. Resultado=0, LED=0, ocupado=0, estouro=0. Internal acc, index and captured operands are cleared.
- States:
  - OCIOSO
  - CALC
  - FIM
- OCIOSO, inicio=1:
  - Capture X and all of COEF into internal registers.
  - acc ← COEF[GRAU], i ← GRAU-1, estouro ← 0.
  - Go to CALC.
  - Inputs are not used after capture.
- CALC, every cycle:
  - acc ← acc·Xc + Cc[i], unsigned, where Xc and Cc are the captured X and COEF.
  - i ← i-1.
  - When the step with i=0 is done: Resultado ← new acc, go to FIM.
- FIM: LED=1. pronto=1 → OCIOSO and LED clears. Resultado is retained.
- Arithmetic:
  - The full product is 2·WIDTH bits; the sum is WIDTH+1 bits.
  - Overflow in a step means the product ≥ 2^WIDTH or the sum ≥ 2^WIDTH.
  - Any overflow step sets estouro. It stays set until the next accepted start or a reset.
  - Without saturation, acc keeps the low WIDTH bits.
- Ignored inputs:
  - inicio in CALC or FIM is ignored.
  - pronto in OCIOSO or CALC is ignored.
- Simultaneous inicio=1 and pronto=1 in FIM: pronto wins and the block goes to OCIOSO. inicio is not accepted; it must be asserted again in OCIOSO.
- Reset mid-CALC or mid-FIM: the evaluation is abandoned and all outputs return to their reset values immediately.

## Timing

- Start edge E0 samples inicio=1. The GRAU CALC steps occur at edges E1..E_GRAU.
- ocupado is high from after E0 until after E_GRAU.
- Resultado and LED become valid after E_GRAU, i.e. a latency of GRAU cycles from the start edge.
- Minimum period between starts is GRAU+2 cycles: start, GRAU steps, one FIM cycle with pronto.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- POLI_SAT_EN defined: saturating arithmetic.
  - On an overflow step, acc ← {WIDTH{1'b1}}.
  - Later steps operate on the saturated value; X=0 can still yield COEF[0].
  - estouro behaves the same as without the macro.
- POLI_SAT_EN undefined: modulo-2^WIDTH wrap-around, with estouro still reported.

## Test plan

- WIDTH=16, GRAU=2, X=2, COEF[2]=1, COEF[1]=3, COEF[0]=4; pulse inicio for one cycle → ocupado high for 2 cycles, then Resultado=14, LED=1, estouro=0. Pulse pronto → LED=0 and Resultado stays 14.
- GRAU=4, X=3, all coefficients 1 → Resultado=121 with LED rising exactly 4 cycles after the start edge.
- GRAU=2, X=16'h0100, COEF[2]=1, others 0:
  - Without the macro → Resultado=0, estouro=1.
  - With POLI_SAT_EN → Resultado=16'hFFFF, estouro=1.
  - Next start with the first test's values → estouro=0, Resultado=14.
- Drive rst=0 asynchronously during CALC of the GRAU=4 case → outputs are 0 immediately. After release, no LED appears without a new inicio.
- Hold inicio=1 throughout CALC and change X mid-calculation → result matches the captured operands and no restart occurs. In FIM, assert inicio and pronto together → OCIOSO, and no new CALC starts until inicio is seen in OCIOSO.
